// File: rtl/parq_pkg.sv
// Shared encodings for the parking-gate sensor emulator: FSM states, direction
// codes and the {a,b} sensor pattern emitted in each phase of a car pass.
package parq_pkg;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PH1  = 3'd1;
  localparam logic [2:0] PH2  = 3'd2;
  localparam logic [2:0] PH3  = 3'd3;
  localparam logic [2:0] GAP  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = IDLE,
    ST_PH1  = PH1,
    ST_PH2  = PH2,
    ST_PH3  = PH3,
    ST_GAP  = GAP
  } state_t;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  // {a,b} per phase; consecutive patterns differ in exactly one line.
  localparam logic [1:0] PAT_IN_PH1  = 2'b10;
  localparam logic [1:0] PAT_IN_PH2  = 2'b11;
  localparam logic [1:0] PAT_IN_PH3  = 2'b10;
  localparam logic [1:0] PAT_OUT_PH1 = 2'b01;
  localparam logic [1:0] PAT_OUT_PH2 = 2'b11;
  localparam logic [1:0] PAT_OUT_PH3 = 2'b10;
  localparam logic [1:0] PAT_IDLE    = 2'b00;

  function automatic logic [1:0] phase_pattern(input state_t st, input logic dir);
    logic [1:0] pat;
    pat = PAT_IDLE;
    case (st)
      ST_PH1:  pat = (dir == DIR_IN) ? PAT_IN_PH1 : PAT_OUT_PH1;
      ST_PH2:  pat = (dir == DIR_IN) ? PAT_IN_PH2 : PAT_OUT_PH2;
      ST_PH3:  pat = (dir == DIR_IN) ? PAT_IN_PH3 : PAT_OUT_PH3;
      default: pat = PAT_IDLE;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/parq_dwell_timer.sv
// Loadable down-counter used for both the per-phase dwell and the trailing gap;
// zero is high while the count sits at 0, which marks the last cycle of a phase.
module parq_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/parq_sensor_gen.sv
// Emulates the two parking-gate photo sensors for one car pass per start request.
// Optional build macro PARQ_SENT_COUNT_EN adds a mod-16 count of completed entry passes.
module parq_sensor_gen
  import parq_pkg::*;
#(
  parameter int DWELL_W = 16,
  parameter int GAP_CYC = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done,
  output logic [3:0]         sent_count
);

  localparam logic [DWELL_W-1:0] GAP_LOAD = DWELL_W'(GAP_CYC - 1);

  state_t             state_q, state_n;
  logic               dir_q, dir_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic               tmr_load;
  logic [DWELL_W-1:0] tmr_value;
  logic               tmr_zero;

  parq_dwell_timer #(.W(DWELL_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .en    (state_q != ST_IDLE),
    .zero  (tmr_zero)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state_q;
    dir_n     = dir_q;
    dwell_n   = dwell_q;
    tmr_load  = 1'b0;
    tmr_value = dwell_q - 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_n   = ST_PH1;
          dir_n     = dir;
          dwell_n   = (dwell == '0) ? DWELL_W'(1) : dwell;
          tmr_load  = 1'b1;
          tmr_value = dwell_n - 1'b1;
        end
      end
      ST_PH1: if (tmr_zero) begin state_n = ST_PH2; tmr_load = 1'b1; end
      ST_PH2: if (tmr_zero) begin state_n = ST_PH3; tmr_load = 1'b1; end
      ST_PH3: begin
        if (tmr_zero) begin
          state_n   = ST_GAP;
          tmr_load  = 1'b1;
          tmr_value = GAP_LOAD;
        end
      end
      ST_GAP:  if (tmr_zero) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Sensor lines are registered from the next state so they change with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_IN;
      dwell_q <= '0;
      a       <= 1'b0;
      b       <= 1'b0;
    end else begin
      state_q <= state_n;
      dir_q   <= dir_n;
      dwell_q <= dwell_n;
      {a, b}  <= phase_pattern(state_n, dir_n);
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_GAP) && tmr_zero;

`ifdef PARQ_SENT_COUNT_EN
  logic [3:0] sent_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sent_q <= 4'd0;
    end else if (done && (dir_q == DIR_IN)) begin
      sent_q <= sent_q + 4'd1;
    end
  end

  assign sent_count = sent_q;
`else
  assign sent_count = 4'd0;
`endif

endmodule

// File: tb/tb_parq_sensor_gen.sv
// Directed self-checking bench for parq_sensor_gen: pass traces, counter model,
// start masking, back-to-back passes, mid-pass reset and sent_count wrap.
module tb_parq_sensor_gen;

  localparam int GAP_CYC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        dir;
  logic [15:0] dwell;
  logic        a, b, busy, done;
  logic [3:0]  sent_count;

  int total = 0;
  int bad   = 0;
  int exp_sent = 0;

  // Car-counting receiver model and single-line-change monitor.
  int         car_count = 0;
  logic [1:0] hist [3];
  int         hist_n = 0;
  logic [1:0] prev_ab = 2'b00;
  bit         mon_skip = 1'b1;

  parq_sensor_gen #(.DWELL_W(16), .GAP_CYC(GAP_CYC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dir        (dir),
    .dwell      (dwell),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ({a, b} !== prev_ab) begin
      if (!mon_skip) begin
        total++;
        if ((({a, b} ^ prev_ab)) == 2'b11) begin
          bad++;
          $display("FAIL gray_step: ab went %b -> %b, required one-line change", prev_ab, {a, b});
        end
      end
      if ({a, b} == 2'b00) begin
        if (hist_n == 3 && hist[0] == 2'b10 && hist[1] == 2'b11 && hist[2] == 2'b10)
          car_count++;
        hist_n = 0;
      end else begin
        if (hist_n < 3) hist[hist_n] = {a, b};
        hist_n++;
      end
    end
    prev_ab = {a, b};
  end

  function automatic logic [3:0] sent_model();
`ifdef PARQ_SENT_COUNT_EN
    return 4'(exp_sent);
`else
    return 4'd0;
`endif
  endfunction

  function automatic logic [1:0] exp_pattern(input logic d, input int ph);
    if (ph == 0) return d ? 2'b01 : 2'b10;
    if (ph == 1) return 2'b11;
    if (ph == 2) return 2'b10;
    return 2'b00;
  endfunction

  // Assert start for one edge, then scramble dir/dwell to show they are not re-sampled.
  task automatic start_pass(input logic d, input logic [15:0] dw);
    start = 1'b1;
    dir   = d;
    dwell = dw;
    @(negedge clk);
    start = 1'b0;
    dir   = ~d;
    dwell = 16'hBEEF;
  endtask

  // Called in cycle 1 of a pass; returns in the done cycle (cycle 3*D+GAP_CYC).
  task automatic check_pass(input logic d, input logic [15:0] dw, input string name);
    int dd, n;
    logic [3:0] exp_v;
    dd = (dw == 16'd0) ? 1 : int'(dw);
    n  = 3 * dd + GAP_CYC;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) @(negedge clk);
      exp_v = {exp_pattern(d, (c - 1) / dd), 1'b1, (c == n)};
      total++;
      if ({a, b, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL %s cycle %0d: {a,b,busy,done}=%b required %b", name, c, {a, b, busy, done}, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dir = 1'b0; dwell = 16'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({a, b, busy, done, sent_count} !== 8'd0) begin
      bad++;
      $display("FAIL reset_hold: {a,b,busy,done,sent}=%b required 0", {a, b, busy, done, sent_count});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    mon_skip = 1'b0;
    total++;
    if ({a, b, busy, done, sent_count} !== 8'd0) begin
      bad++;
      $display("FAIL reset_idle: {a,b,busy,done,sent}=%b required 0", {a, b, busy, done, sent_count});
    end
  endtask

  task automatic test_entry_pass();
    start_pass(1'b0, 16'd3);
    check_pass(1'b0, 16'd3, "entry_d3");
    exp_sent++;
    @(negedge clk);
    total++;
    if ({a, b, busy, done} !== 4'b0000 || sent_count !== sent_model()) begin
      bad++;
      $display("FAIL entry_after: {a,b,busy,done}=%b sent=%0d required 0000 sent=%0d",
               {a, b, busy, done}, sent_count, sent_model());
    end
  endtask

  task automatic test_counter();
    int base;
    base = car_count;
    start_pass(1'b0, 16'd2);
    check_pass(1'b0, 16'd2, "counter_entry");
    exp_sent++;
    repeat (2) @(negedge clk);
    total++;
    if (car_count != base + 1 || sent_count !== sent_model()) begin
      bad++;
      $display("FAIL counter_entry_inc: counter=%0d sent=%0d required counter=%0d sent=%0d",
               car_count, sent_count, base + 1, sent_model());
    end
    base = car_count;
    start_pass(1'b1, 16'd2);
    check_pass(1'b1, 16'd2, "counter_exit");
    repeat (2) @(negedge clk);
    total++;
    if (car_count != base || sent_count !== sent_model()) begin
      bad++;
      $display("FAIL counter_exit_hold: counter=%0d sent=%0d required counter=%0d sent=%0d",
               car_count, sent_count, base, sent_model());
    end
  endtask

  task automatic test_dwell_zero();
    start_pass(1'b0, 16'd0);
    check_pass(1'b0, 16'd0, "dwell_zero");
    exp_sent++;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL dwell_zero_end: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_start_masking();
    logic [3:0] exp_v;
    start_pass(1'b0, 16'd3);
    repeat (3) @(negedge clk);
    // Cycle 4 is PH2: a late start with dir=1 must not restart the pass.
    start = 1'b1; dir = 1'b1; dwell = 16'd1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 5; c <= 13; c++) begin
      if (c > 5) @(negedge clk);
      exp_v = {exp_pattern(1'b0, (c - 1) / 3), 1'b1, (c == 13)};
      total++;
      if ({a, b, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL ignore_start cycle %0d: {a,b,busy,done}=%b required %b", c, {a, b, busy, done}, exp_v);
      end
    end
    exp_sent++;
    // Held from the done cycle: ignored there, accepted the cycle after.
    start = 1'b1; dir = 1'b0; dwell = 16'd1;
    @(negedge clk);
    total++;
    if ({a, b, busy, done} !== 4'b0000) begin
      bad++;
      $display("FAIL start_in_done: {a,b,busy,done}=%b required 0000", {a, b, busy, done});
    end
    @(negedge clk);
    start = 1'b0;
    check_pass(1'b0, 16'd1, "after_done_pass");
    exp_sent++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_pass();
    start_pass(1'b0, 16'd3);
    repeat (3) @(negedge clk);
    total++;
    if ({a, b} !== 2'b11) begin
      bad++;
      $display("FAIL mid_reset_ph2: ab=%b required 11", {a, b});
    end
    mon_skip = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_sent = 0;
    total++;
    if ({a, b, busy, done, sent_count} !== 8'd0) begin
      bad++;
      $display("FAIL mid_reset_after: {a,b,busy,done,sent}=%b required 0", {a, b, busy, done, sent_count});
    end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_quiet %0d: busy=%b done=%b required 0 0", c, busy, done);
      end
    end
    mon_skip = 1'b0;
  endtask

  task automatic test_back_to_back();
    int base;
    base = car_count;
    for (int i = 0; i < 17; i++) begin
      start_pass(1'b0, 16'd1);
      check_pass(1'b0, 16'd1, "b2b");
      exp_sent++;
      @(negedge clk);
      if (i == 15) begin
        total++;
        if (sent_count !== sent_model()) begin
          bad++;
          $display("FAIL b2b_wrap16: sent=%0d required %0d", sent_count, sent_model());
        end
      end
    end
    repeat (2) @(negedge clk);
    total++;
    if (car_count != base + 17 || sent_count !== sent_model()) begin
      bad++;
      $display("FAIL b2b_total: counter_delta=%0d sent=%0d required 17 sent=%0d",
               car_count - base, sent_count, sent_model());
    end
`ifdef PARQ_SENT_COUNT_EN
    total++;
    if (sent_count !== 4'(car_count - base)) begin
      bad++;
      $display("FAIL b2b_agree: sent=%0d counter_delta_mod16=%0d", sent_count, 4'(car_count - base));
    end
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dir = 1'b0; dwell = 16'd0;
    test_reset();
    test_entry_pass();
    test_counter();
    test_dwell_zero();
    test_start_masking();
    test_reset_mid_pass();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
